// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: operands captured once, DIGIT bits summed per clock
// through a ripple chain, carry held in a register between digits.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Ci,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             OV
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [DIGIT-1:0]       sum_dig;
    logic [DIGIT:0]         c;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_shift;

    // Digit ripple chain; c[DIGIT-1] is the carry into the digit's top bit.
    always_comb begin
        c       = '0;
        sum_dig = '0;
        c[0]    = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            sum_dig[i] = xs_q[i] ^ ys_q[i] ^ c[i];
            c[i+1]     = (xs_q[i] & ys_q[i]) | (c[i] & (xs_q[i] ^ ys_q[i]));
        end
    end

    // New digit enters at the MSB end so the first digit ends up at bit 0.
    assign res_cat   = {sum_dig, res_q};
    assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            RUN: begin
                xs_d    = xs_q >> DIGIT;
                ys_d    = ys_q >> DIGIT;
                res_d   = res_shift;
                carry_d = c[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIN;
                    s_d     = res_shift;
                    co_d    = c[DIGIT];
                    ov_d    = c[DIGIT] ^ c[DIGIT-1];
                end
            end
            IDLE, FIN: begin
                state_d = IDLE;
                if (START) begin
                    state_d = RUN;
                    xs_d    = X;
                    ys_d    = SUB ? ~Y : Y;
                    carry_d = Ci ^ SUB;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign S    = s_q;
    assign Co   = co_q;
    assign OV   = ov_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench: four instances (16/4, 8/1, 8/8, 32/8) checked against an
// arithmetic reference model, including DONE latency.
module tb_digit_serial_addsub;
    localparam int WS [4] = '{16, 8, 8, 32};
    localparam int DS [4] = '{4, 1, 8, 8};
    localparam int NS [4] = '{4, 8, 1, 4};

    typedef struct {
        int          g;
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          dcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = '0;
    logic        sub = 1'b0;
    logic        ci = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [3:0]  busy, done, co, ov;
    logic [31:0] s_o [4];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : gd
        localparam int W = WS[g];
        logic [W-1:0] s_w;
        digit_serial_addsub #(.WIDTH(W), .DIGIT(DS[g])) dut (
            .CLK(clk), .RST(rst), .START(start[g]), .SUB(sub),
            .X(x[W-1:0]), .Y(y[W-1:0]), .Ci(ci),
            .BUSY(busy[g]), .DONE(done[g]), .S(s_w), .Co(co[g]), .OV(ov[g])
        );
        assign s_o[g] = 32'(s_w);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for S/Co, signed range for OV.
    function automatic exp_t model(int g, logic [31:0] a, logic [31:0] b, logic sb_i, logic c_i);
        exp_t   e;
        int     w = WS[g];
        longint m = (64'sd1 <<< w) - 1;
        longint av = longint'(a) & m;
        longint bv = longint'(b) & m;
        longint cv = longint'(c_i);
        longint half = 64'sd1 <<< (w - 1);
        longint sa = (av >= half) ? av - (m + 1) : av;
        longint sbv = (bv >= half) ? bv - (m + 1) : bv;
        longint r, sr;
        if (!sb_i) begin
            r    = av + bv + cv;
            e.co = ((r >> w) & 1) != 0;
            sr   = sa + sbv + cv;
        end else begin
            r    = av - bv - cv;
            e.co = (av >= bv + cv);
            sr   = sa - sbv - cv;
        end
        e.s    = 32'(r & m);
        e.ov   = (sr >= half) || (sr < -half);
        e.g    = g;
        e.dcyc = 0;
        return e;
    endfunction

    // Inputs driven on the falling edge; the next rising edge is the accept edge.
    task automatic op(input int g, input logic [31:0] a, input logic [31:0] b,
                      input logic sb_i, input logic c_i, input bit push);
        exp_t e;
        @(negedge clk);
        x = a; y = b; sub = sb_i; ci = c_i; start[g] = 1'b1;
        if (push) begin
            e = model(g, a, b, sb_i, c_i);
            e.dcyc = cyc + 1 + NS[g];
            sb.push_back(e);
        end
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                          input logic sb_i, input logic c_i);
        op(g, a, b, sb_i, c_i, 1'b1);
        wait_empty(40);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (done[g]) begin
                if (sb.size() == 0 || sb[0].g != g) begin
                    chk($sformatf("unexpected_done%0d", g), done[g], 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("S%0d", g), s_o[g], mon_e.s);
                    chk($sformatf("Co%0d", g), co[g], mon_e.co);
                    chk($sformatf("OV%0d", g), ov[g], mon_e.ov);
                    chk($sformatf("latency%0d", g), cyc, mon_e.dcyc);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_S", s_o[0], 0);
        chk("rst_CoOV", {co, ov}, 0);
        rst = 1'b0;

        // Plain add with BUSY profile, then hold of S through IDLE.
        op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, 1'b1);
        chk("busy_run", busy[0], 1);
        repeat (NS[0] - 1) begin
            @(negedge clk);
            chk("busy_run", busy[0], 1);
        end
        @(negedge clk);
        chk("busy_fin", busy[0], 0);
        chk("done_fin", done[0], 1);
        wait_empty(20);
        repeat (3) @(negedge clk);
        chk("S_hold", s_o[0], 32'h5555);
        chk("done_idle", done[0], 0);

        run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
        run_op(0, 32'h7FFF, 32'h0000, 1'b0, 1'b1);
        run_op(0, 32'h0005, 32'h0007, 1'b1, 1'b0);
        run_op(0, 32'h8000, 32'h0001, 1'b1, 1'b0);
        run_op(0, 32'h0010, 32'h0005, 1'b1, 1'b1);

        // Asynchronous reset in the 2nd RUN cycle: outputs clear without a clock edge.
        op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy[0], 0);
        chk("arst_done", done[0], 0);
        chk("arst_S", s_o[0], 0);
        chk("arst_Co", co[0], 0);
        chk("arst_OV", ov[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", done[0], 0);

        // START during RUN is ignored.
        op(0, 32'h1111, 32'h2222, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        x = 32'hABCD; y = 32'h0F0F; sub = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_empty(20);

        // START held high: one accept every N+1 edges.
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            @(negedge clk);
            x = $urandom; y = $urandom; sub = 1'($urandom); ci = 1'($urandom);
            start[0] = 1'b1;
            e = model(0, x, y, sub, ci);
            e.dcyc = cyc + 1 + NS[0];
            sb.push_back(e);
            if (i < 3) repeat (NS[0]) @(negedge clk);
        end
        @(negedge clk);
        start[0] = 1'b0;
        wait_empty(40);

        // Parameter sweep over the other instances.
        for (int g = 1; g < 4; g++) begin
            run_op(g, '1, 32'h1, 1'b0, 1'b0);
            run_op(g, '0, '1, 1'b1, 1'b1);
            for (int i = 0; i < 1000; i++)
                run_op(g, $urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        wait_empty(40);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor: successor to the fixed 4-bit ripple adder.
- Operands are captured once. DIGIT bits are added per clock through an internal DIGIT-wide full-adder ripple chain, with the carry held in a register between digits.
- Trades latency for area on wide datapaths. Carry-in/carry-out semantics are kept, and start/busy/done control, subtract mode and signed overflow are added.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be ≥1 and an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle. Must satisfy 1 ≤ DIGIT ≤ WIDTH. Let N = WIDTH/DIGIT.

Ports:
- CLK    input   1      single clock; all state updates on rising edge
- RST    input   1      reset, asynchronous, active-high
- START  input   1      request; sampled on a CLK rising edge
- SUB    input   1      0: S = X+Y+Ci; 1: S = X−Y−Ci (Ci acts as borrow-in)
- X      input   WIDTH  operand A
- Y      input   WIDTH  operand B
- Ci     input   1      carry-in / borrow-in
- BUSY   output  1      operation in progress
- DONE   output  1      one-cycle completion pulse
- S      output  WIDTH  result, registered
- Co     output  1      carry-out (SUB=1: 1 means no borrow)
- OV     output  1      two's-complement overflow of the result

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE. BUSY=0, DONE=0, S=0, Co=0, OV=0. Digit counter, carry register and operand shift registers are cleared. RST asserted mid-operation aborts the operation; no DONE is produced.
- States:
  - IDLE: BUSY=0, DONE=0.
  - RUN: BUSY=1, DONE=0.
  - FIN: BUSY=0, DONE=1.
- Accept: START=1 at an edge while in IDLE or FIN.
  - Capture X into xs and (SUB ? ~Y : Y) into ys.
  - Set carry register = Ci XOR SUB; clear digit counter; go to RUN.
  - In RUN, START is ignored and input changes have no effect.
- RUN step, at each edge:
  - Digit adder computes xs[DIGIT-1:0] + ys[DIGIT-1:0] + carry.
  - The sum digit is shifted in at the MSB end of the internal result shift register; xs and ys shift right by DIGIT; carry ← digit carry-out.
  - Counter increments, range 0..N−1. On the edge where counter = N−1, go to FIN.
- FIN (exactly one cycle):
  - DONE=1.
  - S ← completed result; Co ← final carry.
  - OV ← carry-into-MSB XOR carry-out-of-MSB, taken from the last digit's ripple chain.
  - Next state: RUN if START=1 (back-to-back accept), else IDLE.
- Output hold: S, Co and OV update only on entry to FIN. They hold their value through IDLE and through any later RUN until the next FIN. Partial results are never visible on S.
- Latency: DONE is high in the cycle following the N-th RUN edge, i.e. N+1 edges after the accept edge. With back-to-back accepts, throughput is one result per N+1 cycles.
- Arithmetic: modulo 2^WIDTH. Co and OV are independent of each other.
  - For SUB=1: Co=0 indicates X < Y+Ci, unsigned.
  - DIGIT=WIDTH degenerates to a one-cycle RUN (N=1); this must be supported.
- START held high continuously gives repeated operations, each using the X/Y/SUB/Ci present at its own accept edge.

Test Plan:
WIDTH=16, DIGIT=4 (N=4) unless noted.
1. Assert RST during the 2nd RUN cycle of X=0x1234,Y=0x4321 → BUSY, DONE, S, Co and OV go to 0 without waiting for CLK. After release, no DONE occurs until a new START.
2. ADD X=0x1234, Y=0x4321, Ci=0 → BUSY=1 for 4 cycles, then DONE=1 for 1 cycle. S=0x5555, Co=0, OV=0. S holds 0x5555 afterwards.
3. ADD X=0xFFFF, Y=0x0001, Ci=0 → S=0x0000, Co=1, OV=0 (carry crosses all digit boundaries). ADD X=0x7FFF, Y=0x0000, Ci=1 → S=0x8000, Co=0, OV=1.
4. SUB X=0x0005, Y=0x0007, Ci=0 → S=0xFFFE, Co=0, OV=0. SUB X=0x8000, Y=0x0001, Ci=0 → S=0x7FFF, Co=1, OV=1. SUB X=0x0010, Y=0x0005, Ci=1 → S=0x000A, Co=1.
5. Pulse START in the 2nd RUN cycle with different operands → ignored; result matches the first operands. Hold START high → DONE pulses every 5 cycles, each matching its own captured operands.
6. Parameter sweep (WIDTH,DIGIT) = (8,1), (8,8), (32,8), with 1000 random X/Y/Ci/SUB each → S/Co/OV match the reference model, and DONE latency = N+1.
